// File: rtl/layer_row_sequencer_if.sv
// Bundle of every non-clock signal of layer_row_sequencer.
//   master : the sequencer side (drives status, output beats, storage buses, ld_ready)
//   slave  : the environment side (drives commands, out_ready, storage read data, loader)
// Groups: job command/status, output beat stream (valid/ready), storage read port,
// loader write request, storage write port.
interface layer_row_sequencer_if #(
    parameter int size      = 3,
    parameter int data_size = 16
);
    localparam int ROW_W = data_size * size;

    // job command / status
    logic              start;
    logic [31:0]       start_layer;
    logic [31:0]       num_layers;
    logic              busy;
    logic              done;
    logic              err;
    // output beat stream
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_data;
    logic [31:0]       out_layer;
    logic [31:0]       out_row;
    logic              out_last;
    // storage read port
    logic [31:0]       st_read_layer_index;
    logic [31:0]       st_read_row_index;
    logic              st_is_read;
    logic [ROW_W-1:0]  st_read_data;
    // loader write request
    logic [ROW_W-1:0]  ld_data;
    logic [31:0]       ld_layer;
    logic [31:0]       ld_row;
    logic              ld_valid;
    logic              ld_ready;
    // storage write port
    logic [ROW_W-1:0]  st_write_data;
    logic [31:0]       st_write_layer_index;
    logic [31:0]       st_write_row_index;
    logic              st_is_write;

    modport master (
        input  start, start_layer, num_layers,
        output busy, done, err,
        output out_valid, out_data, out_layer, out_row, out_last,
        input  out_ready,
        output st_read_layer_index, st_read_row_index, st_is_read,
        input  st_read_data,
        input  ld_data, ld_layer, ld_row, ld_valid,
        output ld_ready,
        output st_write_data, st_write_layer_index, st_write_row_index, st_is_write
    );

    modport slave (
        output start, start_layer, num_layers,
        input  busy, done, err,
        input  out_valid, out_data, out_layer, out_row, out_last,
        output out_ready,
        input  st_read_layer_index, st_read_row_index, st_is_read,
        output st_read_data,
        output ld_data, ld_layer, ld_row, ld_valid,
        input  ld_ready,
        input  st_write_data, st_write_layer_index, st_write_row_index, st_is_write
    );
endinterface

// File: rtl/layer_row_sequencer.sv
// layer_row_sequencer: streams the rows of consecutive layers out of matrix_storage
// as valid/ready beats through one registered output stage, and forwards loader
// writes to storage while stalling writes aimed at the layer being streamed.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      layer_row_sequencer_if.master (command/status, beat stream,
//            storage read/write ports, loader request)
module layer_row_sequencer #(
    parameter int size      = 3,
    parameter int data_size = 16,
    parameter int max_layer = 5
) (
    input logic                    clk,
    input logic                    reset_n,
    layer_row_sequencer_if.master  bus
);
    localparam int          ROW_W   = data_size * size;
    localparam logic [31:0] SIZE_C  = 32'(size);
    localparam logic [31:0] SIZE_M1 = 32'(size - 1);
    localparam logic [31:0] MAX_L   = 32'(max_layer);
    localparam logic [31:0] MAX_M1  = 32'(max_layer - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [31:0]      cur_layer_q, cur_layer_d;
    logic [31:0]      cur_row_q, cur_row_d;
    logic [31:0]      remaining_q, remaining_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [ROW_W-1:0] out_data_q, out_data_d;
    logic [31:0]      out_layer_q, out_layer_d;
    logic [31:0]      out_row_q, out_row_d;
    logic             out_last_q, out_last_d;

    logic             issue;
    logic             is_last;
    logic             ld_ready_c;
    logic             ld_in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_layer_q <= '0;
            cur_row_q   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_layer_q <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_layer_q <= cur_layer_d;
            cur_row_q   <= cur_row_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_layer_q <= out_layer_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
        end
    end

    // A layer is locked against writes only while it is the current read layer.
    assign ld_ready_c  = !(busy_q && (bus.ld_layer == cur_layer_q));
    assign ld_in_range = (bus.ld_layer < MAX_L) && (bus.ld_row < SIZE_C);

    always_comb begin
        state_d     = state_q;
        cur_layer_d = cur_layer_q;
        cur_row_d   = cur_row_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_layer_d = out_layer_q;
        out_row_d   = out_row_q;
        out_last_d  = out_last_q;
        issue       = 1'b0;
        is_last     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.start_layer >= MAX_L) begin
                        err_d = 1'b1;
                    end else if (bus.num_layers == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        cur_layer_d = bus.start_layer;
                        cur_row_d   = '0;
                        remaining_d = (bus.num_layers > MAX_L) ? MAX_L : bus.num_layers;
                        busy_d      = 1'b1;
                        state_d     = STREAM;
                    end
                end
            end
            STREAM: begin
                // The output register is free when empty or being drained this cycle.
                issue   = !out_valid_q || bus.out_ready;
                is_last = (remaining_q == 32'd1) && (cur_row_q == SIZE_M1);
                if (issue) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.st_read_data;
                    out_layer_d = cur_layer_q;
                    out_row_d   = cur_row_q;
                    out_last_d  = is_last;
                    if (cur_row_q == SIZE_M1) begin
                        cur_row_d   = '0;
                        cur_layer_d = (cur_layer_q == MAX_M1) ? '0 : cur_layer_q + 32'd1;
                        remaining_d = remaining_q - 32'd1;
                    end else begin
                        cur_row_d = cur_row_q + 32'd1;
                    end
                    if (is_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Out-of-range loader writes are acknowledged and dropped with an error pulse.
        if (bus.ld_valid && ld_ready_c && !ld_in_range) begin
            err_d = 1'b1;
        end
    end

    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;
    assign bus.err                  = err_q;
    assign bus.out_valid            = out_valid_q;
    assign bus.out_data             = out_data_q;
    assign bus.out_layer            = out_layer_q;
    assign bus.out_row              = out_row_q;
    assign bus.out_last             = out_last_q;
    assign bus.st_read_layer_index  = cur_layer_q;
    assign bus.st_read_row_index    = cur_row_q;
    assign bus.st_is_read           = issue;
    assign bus.ld_ready             = ld_ready_c;
    assign bus.st_write_data        = bus.ld_data;
    assign bus.st_write_layer_index = bus.ld_layer;
    assign bus.st_write_row_index   = bus.ld_row;
    assign bus.st_is_write          = bus.ld_valid && ld_ready_c && ld_in_range;
endmodule

// File: tb/tb_layer_row_sequencer.sv
module tb_layer_row_sequencer;
    localparam int SIZE = 3;
    localparam int DW   = 16;
    localparam int ML   = 5;
    localparam int RW   = DW * SIZE;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    layer_row_sequencer_if #(.size(SIZE), .data_size(DW)) bus ();

    layer_row_sequencer #(.size(SIZE), .data_size(DW), .max_layer(ML)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    typedef struct {
        logic [RW-1:0] data;
        logic [31:0]   layer;
        logic [31:0]   row;
        logic          last;
    } beat_t;

    beat_t exp_q[$];

    logic [RW-1:0] mem     [ML][SIZE];   // storage contents as seen by the DUT
    logic [RW-1:0] ref_mem [ML][SIZE];   // what storage should hold

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rdy_mode = 0;

    int hs_cnt = 0, done_cnt = 0, err_cnt = 0;
    int first_cyc = -1, last_cyc = -1;
    bit busy_seen = 0;
    int base_done, base_err, base_hs;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Storage model: combinational read, write on clock edge.
    always_comb begin
        bus.st_read_data = '0;
        if (bus.st_read_layer_index < 32'(ML) && bus.st_read_row_index < 32'(SIZE))
            bus.st_read_data = mem[bus.st_read_layer_index[2:0]][bus.st_read_row_index[1:0]];
    end

    always @(posedge clk) begin
        if (bus.st_is_write && bus.st_write_layer_index < 32'(ML) && bus.st_write_row_index < 32'(SIZE))
            mem[bus.st_write_layer_index[2:0]][bus.st_write_row_index[1:0]] <= bus.st_write_data;
    end

    // Downstream ready generator.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: case (cyc % 4)
                       0: bus.out_ready = 1'b1;
                       1: bus.out_ready = 1'b0;
                       2: bus.out_ready = 1'b0;
                       default: bus.out_ready = 1'b1;
                   endcase
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops expected beats on every accepted beat and checks stability under stall.
    initial begin
        bit            prev_stall = 0;
        bit            pend_done = 0;
        logic [RW-1:0] p_data = '0;
        logic [31:0]   p_layer = '0, p_row = '0;
        logic          p_last = 1'b0;
        beat_t         e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 0;
                pend_done  = 0;
            end else begin
                if (pend_done) begin
                    check("done_after_last", 64'(bus.done), 64'(1));
                    check("busy_after_done", 64'(bus.busy), 64'(0));
                    pend_done = 0;
                end
                if (prev_stall) begin
                    check("hold_valid", 64'(bus.out_valid), 64'(1));
                    check("hold_data",  64'(bus.out_data), 64'(p_data));
                    check("hold_layer", 64'(bus.out_layer), 64'(p_layer));
                    check("hold_row",   64'(bus.out_row), 64'(p_row));
                    check("hold_last",  64'(bus.out_last), 64'(p_last));
                end
                if (bus.done) done_cnt++;
                if (bus.err)  err_cnt++;
                if (bus.busy) busy_seen = 1;
                if (bus.out_valid && bus.out_ready) begin
                    hs_cnt++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL beat_unexpected: got layer %0d row %0d, no beat required", bus.out_layer, bus.out_row);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data",  64'(bus.out_data), 64'(e.data));
                        check("beat_layer", 64'(bus.out_layer), 64'(e.layer));
                        check("beat_row",   64'(bus.out_row), 64'(e.row));
                        check("beat_last",  64'(bus.out_last), 64'(e.last));
                        if (e.last) pend_done = 1;
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                p_data  = bus.out_data;
                p_layer = bus.out_layer;
                p_row   = bus.out_row;
                p_last  = bus.out_last;
            end
        end
    end

    function automatic int eff_layers(int sl, int nl);
        if (sl >= ML || nl == 0) return 0;
        return (nl > ML) ? ML : nl;
    endfunction

    // Reference model: the job visits layers sl, sl+1, ... (mod ML), every row of each.
    task automatic issue_job(input int sl, input int nl);
        int n_eff;
        n_eff = eff_layers(sl, nl);
        for (int i = 0; i < n_eff; i++) begin
            for (int r = 0; r < SIZE; r++) begin
                beat_t      b;
                logic [2:0] li;
                logic [1:0] ri;
                li = 3'((sl + i) % ML);
                ri = 2'(r);
                b.layer = 32'(li);
                b.row   = 32'(r);
                b.data  = ref_mem[li][ri];
                b.last  = (i == n_eff - 1) && (r == SIZE - 1);
                exp_q.push_back(b);
            end
        end
        base_done = done_cnt;
        base_err  = err_cnt;
        base_hs   = hs_cnt;
        busy_seen = 0;
        first_cyc = -1;
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.start_layer = 32'(sl);
        bus.num_layers  = 32'(nl);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_job(input int sl, input int nl, input int err_inc);
        int n_eff;
        int t;
        n_eff = eff_layers(sl, nl);
        if (n_eff == 0) begin
            repeat (4) @(posedge clk);
            #1;
        end else begin
            t = 0;
            while (done_cnt == base_done && t < 1000) begin
                @(posedge clk);
                t++;
            end
            check("job_timeout", 64'(t < 1000), 64'(1));
            repeat (2) @(posedge clk);
            #1;
        end
        check("beat_count", 64'(hs_cnt - base_hs), 64'(SIZE * n_eff));
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        check("done_count", 64'(done_cnt - base_done), 64'(sl < ML ? 1 : 0));
        check("err_count", 64'(err_cnt - base_err), 64'((sl >= ML ? 1 : 0) + err_inc));
        check("busy_seen", 64'(busy_seen), 64'(n_eff > 0));
        exp_q.delete();
    endtask

    task automatic do_write(input int l, input int r, input logic [RW-1:0] d);
        bit in_range;
        int eb;
        in_range = (l < ML) && (r < SIZE);
        eb = err_cnt;
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b1;
        bus.ld_layer = 32'(l);
        bus.ld_row   = 32'(r);
        bus.ld_data  = d;
        #1;
        check("idle_ld_ready", 64'(bus.ld_ready), 64'(1));
        check("idle_st_is_write", 64'(bus.st_is_write), 64'(in_range));
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        if (in_range) ref_mem[3'(l)][2'(r)] = d;
        @(posedge clk);
        #1;
        check("write_err", 64'(err_cnt - eb), 64'(!in_range));
    endtask

    initial begin
        logic [RW-1:0] d;
        int sl, nl;
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] d;
        int sl, nl, eb;
        bus.start = 1'b0;
        bus.start_layer = '0;
        bus.num_layers = '0;
        bus.ld_valid = 1'b0;
        bus.ld_layer = '0;
        bus.ld_row = '0;
        bus.ld_data = '0;
        for (int l = 0; l < ML; l++) begin
            for (int r = 0; r < SIZE; r++) begin
                d = RW'({$urandom(), $urandom()});
                mem[3'(l)][2'(r)] <= d;
                ref_mem[3'(l)][2'(r)] = d;
            end
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_err", 64'(bus.err), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_out_last", 64'(bus.out_last), 64'(0));
        reset_n = 1'b1;

        // Two layers at full throughput
        rdy_mode = 0;
        issue_job(1, 2);
        wait_job(1, 2, 0);
        check("throughput", 64'(last_cyc - first_cyc), 64'(5));

        // Same job under backpressure
        rdy_mode = 1;
        issue_job(1, 2);
        wait_job(1, 2, 0);

        // Layer wrap, with a start while busy that must be ignored
        rdy_mode = 2;
        issue_job(4, 3);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.start_layer = 32'd9;
        bus.num_layers = 32'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_job(4, 3, 0);

        // Rejected start and empty job
        rdy_mode = 0;
        issue_job(5, 1);
        wait_job(5, 1, 0);
        issue_job(0, 0);
        wait_job(0, 0, 0);

        // Loader writes during a layer-2 stream
        rdy_mode = 1;
        issue_job(2, 1);
        bus.ld_valid = 1'b1;
        bus.ld_layer = 32'd2;
        bus.ld_row   = 32'd0;
        bus.ld_data  = RW'({$urandom(), $urandom()});
        #1;
        check("locked_ld_ready", 64'(bus.ld_ready), 64'(0));
        check("locked_st_is_write", 64'(bus.st_is_write), 64'(0));
        @(posedge clk);
        #1;
        d = RW'({$urandom(), $urandom()});
        bus.ld_layer = 32'd3;
        bus.ld_row   = 32'd1;
        bus.ld_data  = d;
        #1;
        check("free_ld_ready", 64'(bus.ld_ready), 64'(1));
        check("free_st_is_write", 64'(bus.st_is_write), 64'(1));
        check("free_wr_data", 64'(bus.st_write_data), 64'(d));
        check("free_wr_layer", 64'(bus.st_write_layer_index), 64'(3));
        check("free_wr_row", 64'(bus.st_write_row_index), 64'(1));
        ref_mem[3][1] = d;
        @(posedge clk);
        #1;
        bus.ld_layer = 32'd0;
        bus.ld_row   = 32'd3;
        #1;
        check("oor_ld_ready", 64'(bus.ld_ready), 64'(1));
        check("oor_st_is_write", 64'(bus.st_is_write), 64'(0));
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        wait_job(2, 1, 1);
        bus.ld_layer = 32'd2;
        #1;
        check("unlocked_ld_ready", 64'(bus.ld_ready), 64'(1));

        // Read back layers 2 and 3 to confirm which writes landed
        rdy_mode = 0;
        issue_job(2, 2);
        wait_job(2, 2, 0);

        // Reset in the middle of a stream
        issue_job(0, 5);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_done", 64'(bus.done), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(done_cnt - base_done), 64'(0));
        reset_n = 1'b1;
        rdy_mode = 2;
        issue_job(3, 7);
        wait_job(3, 7, 0);

        // Randomized jobs with idle-time loader writes
        for (int k = 0; k < 10; k++) begin
            do_write($urandom_range(0, ML), $urandom_range(0, SIZE), RW'({$urandom(), $urandom()}));
            do_write($urandom_range(0, ML - 1), $urandom_range(0, SIZE - 1), RW'({$urandom(), $urandom()}));
            sl = $urandom_range(0, ML);
            nl = $urandom_range(0, 7);
            rdy_mode = $urandom_range(0, 2);
            issue_job(sl, nl);
            wait_job(sl, nl, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
